// File: rtl/cpl_data_splitter_if.sv
// Completion data splitter bus bundle: request descriptors, AXI4-R beat stream,
// and the header/payload FIFO write ports toward TX.
interface cpl_data_splitter_if #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned LEN_W      = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic [7:0]            req_tag;
    logic [LEN_W-1:0]      req_len_dw;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    logic                  cpl_pay_full;
    logic                  cpl_pay_wren;
    logic [DATA_WIDTH-1:0] cpl_pay_data;
    logic                  cpl_pay_last;

    logic                  cpl_hdr_full;
    logic                  cpl_hdr_wren;
    logic [7:0]            cpl_hdr_tag;
    logic [LEN_W-1:0]      cpl_hdr_len_dw;
    logic [11:0]           cpl_hdr_bcnt;
    logic [2:0]            cpl_hdr_status;

    logic                  err_len;

    // Environment side: issues requests and read data, owns the FIFOs.
    modport master (
        output req_valid, req_tag, req_len_dw,
        output rvalid, rdata, rresp, rlast,
        output cpl_pay_full, cpl_hdr_full,
        input  req_ready, rready,
        input  cpl_pay_wren, cpl_pay_data, cpl_pay_last,
        input  cpl_hdr_wren, cpl_hdr_tag, cpl_hdr_len_dw, cpl_hdr_bcnt, cpl_hdr_status,
        input  err_len
    );

    // Splitter side.
    modport slave (
        input  req_valid, req_tag, req_len_dw,
        input  rvalid, rdata, rresp, rlast,
        input  cpl_pay_full, cpl_hdr_full,
        output req_ready, rready,
        output cpl_pay_wren, cpl_pay_data, cpl_pay_last,
        output cpl_hdr_wren, cpl_hdr_tag, cpl_hdr_len_dw, cpl_hdr_bcnt, cpl_hdr_status,
        output err_len
    );
endinterface

// File: rtl/cpl_data_splitter.sv
// Splits each read request's AXI4-R beat stream into MPS-sized completions,
// writing one header per completion and the payload beats with zero latency.
module cpl_data_splitter #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned MPS_BYTES  = 128,
    parameter int unsigned LEN_W      = 10,
    parameter int unsigned DESC_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    cpl_data_splitter_if.slave bus
);
    localparam int unsigned BEAT_B = DATA_WIDTH / 8;
    localparam int unsigned BPS    = MPS_BYTES / BEAT_B;
    localparam int unsigned BCNT_W = (BPS > 1) ? $clog2(BPS) : 1;
    localparam int unsigned REM_W  = LEN_W + 3;
    localparam int unsigned PTR_W  = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
    localparam logic [2:0]  ST_SC  = 3'b000;
    localparam logic [2:0]  ST_CA  = 3'b100;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    typedef struct packed {
        logic [7:0]       tag;
        logic [LEN_W-1:0] len_dw;
    } desc_t;

    state_t state, state_nxt;

    desc_t            desc_mem [DESC_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             desc_full, desc_empty, push, pop;
    desc_t            head;

    logic [7:0]       cur_tag;
    logic [REM_W-1:0] rem_bytes, rem_init, seg_bytes;
    logic [BCNT_W-1:0] beat_cnt;
    logic             err;

    logic             sof, seg_end, req_end, beat_err, accept;
    logic             req_ready, rready, pay_wren, pay_last, hdr_wren, err_len;

    // Descriptor FIFO with wrap-bit pointers so full and empty are distinguishable.
    assign desc_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign desc_empty = (wr_ptr == rd_ptr);
    assign req_ready  = !desc_full && !rst;
    assign push       = bus.req_valid && req_ready;
    assign head       = desc_mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            desc_mem[wr_ptr[PTR_W-1:0]] <= '{tag: bus.req_tag, len_dw: bus.req_len_dw};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // A zero length field encodes the maximum request size.
    assign rem_init  = (head.len_dw == '0) ? {1'b1, {(LEN_W+2){1'b0}}}
                                           : {1'b0, head.len_dw, 2'b00};
    assign seg_bytes = (rem_bytes < REM_W'(MPS_BYTES)) ? rem_bytes : REM_W'(MPS_BYTES);
    assign sof       = (beat_cnt == '0);
    assign req_end   = (rem_bytes <= REM_W'(BEAT_B));
    assign seg_end   = (beat_cnt == BCNT_W'(BPS - 1)) || req_end;
    assign beat_err  = (bus.rresp != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        rready    = 1'b0;
        accept    = 1'b0;
        pay_wren  = 1'b0;
        pay_last  = 1'b0;
        hdr_wren  = 1'b0;
        err_len   = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (!desc_empty) begin
                        pop       = 1'b1;
                        state_nxt = STREAM;
                    end
                end
                STREAM: begin
                    rready = !bus.cpl_pay_full && !(sof && bus.cpl_hdr_full);
                    accept = bus.rvalid && rready;
                    if (accept) begin
                        pay_wren = 1'b1;
                        pay_last = seg_end || bus.rlast;
                        hdr_wren = sof;
                        // Expected end without rlast drains the rest of the burst.
                        if (req_end) begin
                            err_len   = !bus.rlast;
                            state_nxt = bus.rlast ? IDLE : DRAIN;
                        end else if (bus.rlast) begin
                            err_len   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                DRAIN: begin
                    rready = 1'b1;
                    if (bus.rvalid && bus.rlast) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Per-request tracking: remaining bytes, beat position in segment, sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_tag   <= '0;
            rem_bytes <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
        end else if (pop) begin
            cur_tag   <= head.tag;
            rem_bytes <= rem_init;
            beat_cnt  <= '0;
            err       <= 1'b0;
        end else if (accept) begin
            rem_bytes <= rem_bytes - REM_W'(BEAT_B);
            beat_cnt  <= seg_end ? '0 : beat_cnt + BCNT_W'(1);
            if (beat_err) err <= 1'b1;
        end
    end

    assign bus.req_ready      = req_ready;
    assign bus.rready         = rready;
    assign bus.cpl_pay_wren   = pay_wren;
    assign bus.cpl_pay_data   = pay_wren ? bus.rdata : '0;
    assign bus.cpl_pay_last   = pay_last;
    assign bus.cpl_hdr_wren   = hdr_wren;
    assign bus.cpl_hdr_tag    = hdr_wren ? cur_tag : 8'h00;
    assign bus.cpl_hdr_len_dw = hdr_wren ? LEN_W'(seg_bytes >> 2) : '0;
    assign bus.cpl_hdr_bcnt   = hdr_wren ? 12'(rem_bytes) : 12'h000;
    assign bus.cpl_hdr_status = !hdr_wren ? 3'b000 : ((err || beat_err) ? ST_CA : ST_SC);
    assign bus.err_len        = err_len;
endmodule

// File: tb/tb_cpl_data_splitter.sv
// Directed bench for cpl_data_splitter: per-cycle vector table plus hand-written
// sequences for the 4 KiB request, descriptor FIFO full, and reset mid-request.
module tb_cpl_data_splitter;
    localparam int unsigned DW = 256;
    localparam int unsigned LW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpl_data_splitter_if #(.DATA_WIDTH(DW), .LEN_W(LW)) bus ();

    cpl_data_splitter #(
        .DATA_WIDTH(DW), .MPS_BYTES(128), .LEN_W(LW), .DESC_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic        rst;
        logic        req_valid;
        logic [7:0]  tag;
        logic [9:0]  len;
        logic        rvalid;
        logic [15:0] d;
        logic [1:0]  rresp;
        logic        rlast;
        logic        pay_full;
        logic        hdr_full;
    } in_t;

    typedef struct packed {
        logic        req_ready;
        logic        rready;
        logic        pay_wren;
        logic [15:0] pay_lo;
        logic [15:0] pay_hi;
        logic        pay_last;
        logic        hdr_wren;
        logic [7:0]  hdr_tag;
        logic [9:0]  hdr_len;
        logic [11:0] hdr_bcnt;
        logic [2:0]  hdr_status;
        logic        err_len;
    } out_t;

    typedef struct {
        in_t   i;
        out_t  e;
        string nm;
    } vec_t;

    vec_t tbl[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic in_t i_idle();
        in_t v = '0;
        return v;
    endfunction

    function automatic in_t i_rst();
        in_t v = '0;
        v.rst = 1'b1; v.rvalid = 1'b1; v.d = 16'hEEEE; v.req_valid = 1'b1; v.len = 10'd32;
        return v;
    endfunction

    function automatic in_t i_push(input logic [7:0] t, input logic [9:0] l);
        in_t v = '0;
        v.req_valid = 1'b1; v.tag = t; v.len = l;
        return v;
    endfunction

    function automatic in_t i_beat(input logic [15:0] d, input logic [1:0] r, input logic last);
        in_t v = '0;
        v.rvalid = 1'b1; v.d = d; v.rresp = r; v.rlast = last;
        return v;
    endfunction

    function automatic in_t i_full(input logic [15:0] d, input logic pf, input logic hf);
        in_t v = i_beat(d, 2'b00, 1'b0);
        v.pay_full = pf; v.hdr_full = hf;
        return v;
    endfunction

    function automatic out_t e_zero();
        out_t v = '0;
        return v;
    endfunction

    function automatic out_t e_idle();
        out_t v = '0;
        v.req_ready = 1'b1;
        return v;
    endfunction

    function automatic out_t e_drain();
        out_t v = e_idle();
        v.rready = 1'b1;
        return v;
    endfunction

    function automatic out_t e_beat(input logic [15:0] d, input logic last, input logic el);
        out_t v = e_drain();
        v.pay_wren = 1'b1; v.pay_lo = d; v.pay_hi = d; v.pay_last = last; v.err_len = el;
        return v;
    endfunction

    function automatic out_t e_hdr(input logic [15:0] d, input logic [7:0] t,
                                   input logic [9:0] l, input logic [11:0] b, input logic [2:0] s);
        out_t v = e_beat(d, 1'b0, 1'b0);
        v.hdr_wren = 1'b1; v.hdr_tag = t; v.hdr_len = l; v.hdr_bcnt = b; v.hdr_status = s;
        return v;
    endfunction

    function automatic void add(input in_t i, input out_t e, input string nm);
        vec_t v;
        v.i = i; v.e = e; v.nm = nm;
        tbl.push_back(v);
    endfunction

    // Drive one cycle of inputs after the falling edge, then compare before the rising edge.
    task automatic step(input in_t i, input out_t e, input string nm);
        out_t a;
        @(negedge clk);
        rst              = i.rst;
        bus.req_valid    = i.req_valid;
        bus.req_tag      = i.tag;
        bus.req_len_dw   = i.len;
        bus.rvalid       = i.rvalid;
        bus.rdata        = {16{i.d}};
        bus.rresp        = i.rresp;
        bus.rlast        = i.rlast;
        bus.cpl_pay_full = i.pay_full;
        bus.cpl_hdr_full = i.hdr_full;
        #2;
        a.req_ready  = bus.req_ready;
        a.rready     = bus.rready;
        a.pay_wren   = bus.cpl_pay_wren;
        a.pay_lo     = bus.cpl_pay_data[15:0];
        a.pay_hi     = bus.cpl_pay_data[DW-1 -: 16];
        a.pay_last   = bus.cpl_pay_last;
        a.hdr_wren   = bus.cpl_hdr_wren;
        a.hdr_tag    = bus.cpl_hdr_tag;
        a.hdr_len    = bus.cpl_hdr_len_dw;
        a.hdr_bcnt   = bus.cpl_hdr_bcnt;
        a.hdr_status = bus.cpl_hdr_status;
        a.err_len    = bus.err_len;
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, a, e);
    endtask

    initial begin
        in_t  vi;
        out_t ve;

        bus.req_valid = 1'b0; bus.req_tag = '0; bus.req_len_dw = '0;
        bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0;
        bus.cpl_pay_full = 1'b0; bus.cpl_hdr_full = 1'b0;

        add(i_rst(), e_zero(), "reset0");
        add(i_rst(), e_zero(), "reset1");
        // Single completion, tag 5, 32 DW.
        add(i_push(8'd5, 10'd32),          e_idle(), "s1_push");
        add(i_idle(),                      e_idle(), "s1_pop");
        add(i_beat(16'h0101, 2'b00, 1'b0), e_hdr(16'h0101, 8'd5, 10'd32, 12'd128, 3'b000), "s1_b1");
        add(i_beat(16'h0102, 2'b00, 1'b0), e_beat(16'h0102, 1'b0, 1'b0), "s1_b2");
        add(i_beat(16'h0103, 2'b00, 1'b0), e_beat(16'h0103, 1'b0, 1'b0), "s1_b3");
        add(i_beat(16'h0104, 2'b00, 1'b1), e_beat(16'h0104, 1'b1, 1'b0), "s1_b4");
        // 80 DW split 32/32/16, with payload and header backpressure.
        add(i_push(8'd7, 10'd80),          e_idle(), "s2_push");
        add(i_idle(),                      e_idle(), "s2_pop");
        add(i_beat(16'h0201, 2'b00, 1'b0), e_hdr(16'h0201, 8'd7, 10'd32, 12'd320, 3'b000), "s2_b1");
        add(i_full(16'h0202, 1'b0, 1'b1),  e_beat(16'h0202, 1'b0, 1'b0), "s2_b2_hfull_mid");
        add(i_beat(16'h0203, 2'b00, 1'b0), e_beat(16'h0203, 1'b0, 1'b0), "s2_b3");
        add(i_beat(16'h0204, 2'b00, 1'b0), e_beat(16'h0204, 1'b1, 1'b0), "s2_b4");
        add(i_beat(16'h0205, 2'b00, 1'b0), e_hdr(16'h0205, 8'd7, 10'd32, 12'd192, 3'b000), "s2_b5");
        add(i_full(16'h0206, 1'b1, 1'b0),  e_idle(), "s2_pfull1");
        add(i_full(16'h0206, 1'b1, 1'b0),  e_idle(), "s2_pfull2");
        add(i_full(16'h0206, 1'b1, 1'b0),  e_idle(), "s2_pfull3");
        add(i_beat(16'h0206, 2'b00, 1'b0), e_beat(16'h0206, 1'b0, 1'b0), "s2_b6");
        add(i_beat(16'h0207, 2'b00, 1'b0), e_beat(16'h0207, 1'b0, 1'b0), "s2_b7");
        add(i_beat(16'h0208, 2'b00, 1'b0), e_beat(16'h0208, 1'b1, 1'b0), "s2_b8");
        add(i_full(16'h0209, 1'b0, 1'b1),  e_idle(), "s2_hfull_sof");
        add(i_beat(16'h0209, 2'b00, 1'b0), e_hdr(16'h0209, 8'd7, 10'd16, 12'd64, 3'b000), "s2_b9");
        add(i_beat(16'h020A, 2'b00, 1'b1), e_beat(16'h020A, 1'b1, 1'b0), "s2_b10");
        // rresp error on beat 2 of 64 DW: first header already SC, second CA.
        add(i_push(8'd9, 10'd64),          e_idle(), "s3_push");
        add(i_idle(),                      e_idle(), "s3_pop");
        add(i_beat(16'h0301, 2'b00, 1'b0), e_hdr(16'h0301, 8'd9, 10'd32, 12'd256, 3'b000), "s3_b1");
        add(i_beat(16'h0302, 2'b10, 1'b0), e_beat(16'h0302, 1'b0, 1'b0), "s3_b2_err");
        add(i_beat(16'h0303, 2'b00, 1'b0), e_beat(16'h0303, 1'b0, 1'b0), "s3_b3");
        add(i_beat(16'h0304, 2'b00, 1'b0), e_beat(16'h0304, 1'b1, 1'b0), "s3_b4");
        add(i_beat(16'h0305, 2'b00, 1'b0), e_hdr(16'h0305, 8'd9, 10'd32, 12'd128, 3'b100), "s3_b5_ca");
        add(i_beat(16'h0306, 2'b00, 1'b0), e_beat(16'h0306, 1'b0, 1'b0), "s3_b6");
        add(i_beat(16'h0307, 2'b00, 1'b0), e_beat(16'h0307, 1'b0, 1'b0), "s3_b7");
        add(i_beat(16'h0308, 2'b00, 1'b1), e_beat(16'h0308, 1'b1, 1'b0), "s3_b8");
        // Early rlast; next descriptor pushed during the pop cycle starts cleanly.
        add(i_push(8'd3, 10'd32),          e_idle(), "s4_push");
        add(i_push(8'd4, 10'd32),          e_idle(), "s4_pop_push");
        add(i_beat(16'h0401, 2'b00, 1'b0), e_hdr(16'h0401, 8'd3, 10'd32, 12'd128, 3'b000), "s4_b1");
        add(i_beat(16'h0402, 2'b00, 1'b1), e_beat(16'h0402, 1'b1, 1'b1), "s4_b2_early");
        add(i_idle(),                      e_idle(), "s4_pop2");
        add(i_beat(16'h0411, 2'b00, 1'b0), e_hdr(16'h0411, 8'd4, 10'd32, 12'd128, 3'b000), "s4_n1");
        add(i_beat(16'h0412, 2'b00, 1'b0), e_beat(16'h0412, 1'b0, 1'b0), "s4_n2");
        add(i_beat(16'h0413, 2'b00, 1'b0), e_beat(16'h0413, 1'b0, 1'b0), "s4_n3");
        add(i_beat(16'h0414, 2'b00, 1'b1), e_beat(16'h0414, 1'b1, 1'b0), "s4_n4");
        // Missing rlast: final beat flagged, then drain to the real rlast.
        add(i_push(8'd6, 10'd32),          e_idle(), "s5_push");
        add(i_idle(),                      e_idle(), "s5_pop");
        add(i_beat(16'h0501, 2'b00, 1'b0), e_hdr(16'h0501, 8'd6, 10'd32, 12'd128, 3'b000), "s5_b1");
        add(i_beat(16'h0502, 2'b00, 1'b0), e_beat(16'h0502, 1'b0, 1'b0), "s5_b2");
        add(i_beat(16'h0503, 2'b00, 1'b0), e_beat(16'h0503, 1'b0, 1'b0), "s5_b3");
        add(i_beat(16'h0504, 2'b00, 1'b0), e_beat(16'h0504, 1'b1, 1'b1), "s5_b4_nolast");
        add(i_idle(),                      e_drain(), "s5_drain_idle");
        add(i_beat(16'h0505, 2'b00, 1'b0), e_drain(), "s5_drain_beat");
        add(i_beat(16'h0506, 2'b00, 1'b1), e_drain(), "s5_drain_last");
        add(i_beat(16'h0507, 2'b00, 1'b0), e_idle(), "s5_back_idle");

        foreach (tbl[k]) step(tbl[k].i, tbl[k].e, tbl[k].nm);

        // 4 KiB request (len 0) while the descriptor FIFO is filled and overfilled.
        step(i_push(8'h11, 10'd0), e_idle(), "l0_push");
        step(i_idle(), e_idle(), "l0_pop");
        for (int b = 0; b < 128; b++) begin
            vi = i_beat(16'(16'h4000 + b), 2'b00, (b == 127));
            if (b >= 1 && b <= 5) begin
                vi.req_valid = 1'b1;
                vi.tag       = 8'(8'h1F + b);
                vi.len       = 10'd32;
            end
            if (b % 4 == 0) ve = e_hdr(16'(16'h4000 + b), 8'h11, 10'd32, 12'(4096 - 32 * b), 3'b000);
            else            ve = e_beat(16'(16'h4000 + b), (b % 4 == 3), 1'b0);
            ve.req_ready = (b < 5);
            step(vi, ve, $sformatf("l0_beat%0d", b));
        end
        for (int q = 0; q < 4; q++) begin
            ve = e_idle();
            ve.req_ready = (q != 0);
            step(i_idle(), ve, $sformatf("q%0d_pop", q));
            for (int b = 0; b < 4; b++) begin
                if (b == 0) ve = e_hdr(16'(16'h5000 + 16 * q), 8'(8'h20 + q), 10'd32, 12'd128, 3'b000);
                else        ve = e_beat(16'(16'h5000 + 16 * q + b), (b == 3), 1'b0);
                step(i_beat(16'(16'h5000 + 16 * q + b), 2'b00, (b == 3)), ve, $sformatf("q%0d_b%0d", q, b));
            end
        end
        step(i_beat(16'h5555, 2'b00, 1'b0), e_idle(), "ovf_dropped0");
        step(i_beat(16'h5555, 2'b00, 1'b0), e_idle(), "ovf_dropped1");

        // Reset mid-request discards in-flight state and queued descriptors.
        step(i_push(8'h30, 10'd32), e_idle(), "r_push");
        step(i_push(8'h31, 10'd32), e_idle(), "r_pop_push");
        step(i_beat(16'h6001, 2'b00, 1'b0), e_hdr(16'h6001, 8'h30, 10'd32, 12'd128, 3'b000), "r_b1");
        step(i_rst(), e_zero(), "r_rst0");
        step(i_rst(), e_zero(), "r_rst1");
        step(i_beat(16'h6002, 2'b00, 1'b0), e_idle(), "r_flushed0");
        step(i_beat(16'h6002, 2'b00, 1'b0), e_idle(), "r_flushed1");
        step(i_push(8'h32, 10'd32), e_idle(), "r2_push");
        step(i_idle(), e_idle(), "r2_pop");
        for (int b = 0; b < 4; b++) begin
            if (b == 0) ve = e_hdr(16'h6100, 8'h32, 10'd32, 12'd128, 3'b000);
            else        ve = e_beat(16'(16'h6100 + b), (b == 3), 1'b0);
            step(i_beat(16'(16'h6100 + b), 2'b00, (b == 3)), ve, $sformatf("r2_b%0d", b));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
